comp_serial: RTL

Parametrised multi-cycle magnitude comparator, the successor to the fixed 4-bit combinational comparator.
- Compares two WIDTH-bit operands MSB-first, one CHUNK-bit slice per clock.
- Supports unsigned and two's-complement signed modes.
- Exits early on the first differing slice when EARLY_EXIT=1.
- Sits beside datapath blocks that need wide compares without a long combinational chain; uses a start/busy/done handshake.

---
 rtl/comp_pkg.sv | 22 ++
 rtl/comp_chunk.sv | 21 ++
 rtl/comp_serial.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/comp_pkg.sv
// Shared types, result codes and sizing helpers for the serial magnitude comparator.
package comp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } comp_state_t;

  localparam logic [1:0] RES_EQ = 2'b00;
  localparam logic [1:0] RES_GT = 2'b01;
  localparam logic [1:0] RES_LS = 2'b10;

  function automatic int num_chunks(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Slice index needs at least one bit even for a single-slice compare.
  function automatic int idx_width(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/comp_chunk.sv
// Combinational CHUNK-bit unsigned slice comparator returning a 2-bit result code.
module comp_chunk
  import comp_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic [1:0]       res
);

  always_comb begin
    res = RES_EQ;
    if (a > b) begin
      res = RES_GT;
    end else if (a < b) begin
      res = RES_LS;
    end
  end

endmodule

// File: rtl/comp_serial.sv
// Multi-cycle MSB-first magnitude comparator with start/busy/done handshake,
// unsigned or two's-complement operands, and optional early exit.
module comp_serial
  import comp_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int CHUNK      = 4,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             ls
);

  localparam int NCHUNK = num_chunks(WIDTH, CHUNK);
  localparam int IW     = idx_width(NCHUNK);
  localparam logic [IW-1:0]    LAST     = IW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);

  comp_state_t      state, state_d;
  logic [IW-1:0]    idx, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             pend_valid, pend_valid_d;
  logic [1:0]       pend_res, pend_res_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             gt_q, gt_d, eq_q, eq_d, ls_q, ls_d;

  logic [CHUNK-1:0] a_sl [NCHUNK];
  logic [CHUNK-1:0] b_sl [NCHUNK];
  logic [1:0]       slice_res;
  logic [1:0]       final_res;
  logic             finish;

  for (genvar i = 0; i < NCHUNK; i++) begin : g_slice
    assign a_sl[i] = a_q[WIDTH-1-i*CHUNK -: CHUNK];
    assign b_sl[i] = b_q[WIDTH-1-i*CHUNK -: CHUNK];
  end

  comp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a   (a_sl[idx]),
    .b   (b_sl[idx]),
    .res (slice_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      a_q        <= '0;
      b_q        <= '0;
      pend_valid <= 1'b0;
      pend_res   <= RES_EQ;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      gt_q       <= 1'b0;
      eq_q       <= 1'b0;
      ls_q       <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      a_q        <= a_d;
      b_q        <= b_d;
      pend_valid <= pend_valid_d;
      pend_res   <= pend_res_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      gt_q       <= gt_d;
      eq_q       <= eq_d;
      ls_q       <= ls_d;
    end
  end

  always_comb begin
    state_d      = state;
    idx_d        = idx;
    a_d          = a_q;
    b_d          = b_q;
    pend_valid_d = pend_valid;
    pend_res_d   = pend_res;
    busy_d       = busy_q;
    done_d       = 1'b0;
    gt_d         = gt_q;
    eq_d         = eq_q;
    ls_d         = ls_q;
    final_res    = RES_EQ;
    finish       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          // Flipping both sign bits maps two's-complement order onto unsigned order.
          a_d          = signed_mode ? (a ^ MSB_MASK) : a;
          b_d          = signed_mode ? (b ^ MSB_MASK) : b;
          idx_d        = '0;
          pend_valid_d = 1'b0;
          pend_res_d   = RES_EQ;
          busy_d       = 1'b1;
          state_d      = CMP;
        end
      end
      CMP: begin
        if ((EARLY_EXIT != 0) && (slice_res != RES_EQ)) begin
          finish    = 1'b1;
          final_res = slice_res;
        end else begin
          // The most significant differing slice decides; later ones are ignored.
          if ((slice_res != RES_EQ) && !pend_valid) begin
            pend_valid_d = 1'b1;
            pend_res_d   = slice_res;
          end
          if (idx == LAST) begin
            finish    = 1'b1;
            final_res = pend_valid_d ? pend_res_d : RES_EQ;
          end else begin
            idx_d = idx + IW'(1);
          end
        end
        if (finish) begin
          gt_d    = (final_res == RES_GT);
          eq_d    = (final_res == RES_EQ);
          ls_d    = (final_res == RES_LS);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign gt   = gt_q;
  assign eq   = eq_q;
  assign ls   = ls_q;

endmodule
